// File: rtl/frame_payload_capture.sv
// Captures PAYLOAD_BITS serial bits MSB-first after each header match from the
// detector and presents them on a valid/ready port with a frame counter and overrun flag.
module frame_payload_capture #(
   parameter int PAYLOAD_BITS = 8,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    async_reset_n,
   input  logic                    in_stream,
   input  logic                    detect,
   output logic [PAYLOAD_BITS-1:0] data_out,
   output logic                    data_valid,
   input  logic                    data_ready,
   output logic [CNT_WIDTH-1:0]    frame_count,
   output logic                    overrun,
   output logic                    busy
);

   localparam int BIT_CNT_W = (PAYLOAD_BITS > 2) ? $clog2(PAYLOAD_BITS) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PAYLOAD_BITS - 1);

   typedef enum logic {
      IDLE,
      CAPTURE
   } state_t;

   state_t                  state;
   logic [PAYLOAD_BITS-2:0] shift_reg;
   logic [BIT_CNT_W-1:0]    bit_cnt;
   logic [PAYLOAD_BITS-1:0] word_next;
   logic                    out_free;

   // The incoming bit completes the word on the final capture edge.
   assign word_next = {shift_reg, in_stream};
   assign out_free  = !data_valid || data_ready;

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         state       <= IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_count <= '0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (detect) begin
                  state   <= CAPTURE;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
               end
            end

            CAPTURE: begin
               shift_reg <= word_next[PAYLOAD_BITS-2:0];
               bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
               // detect is deliberately ignored here so payload bits that look like a header never nest.
               if (bit_cnt == LAST_BIT) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  bit_cnt <= '0;
                  if (out_free) begin
                     data_out    <= word_next;
                     data_valid  <= 1'b1;
                     frame_count <= frame_count + CNT_WIDTH'(1);
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
